// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies one sprite from a synchronous ROM onto the VGA framebuffer
// Walks ROM addresses row-major; one pipeline stage aligns row/col with the ROM data.
module sprite_blitter #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  originX,
  input  logic [6:0]  originY,
  output logic [10:0] spriteAddress,
  input  logic [2:0]  spriteColour,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] LAST_ADDR = 11'(SPRITE_W * SPRITE_H - 1);
  localparam logic [5:0]  LAST_COL  = 6'(SPRITE_W - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  ox;
  logic [6:0]  oy;
  logic [5:0]  row, col;
  logic [10:0] addr;
  logic        pv;
  logic [5:0]  prow, pcol;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  colour_q;
  logic [8:0]  sum_x, sum_y;
  logic        last_addr;

  assign last_addr     = (addr == LAST_ADDR);
  assign spriteAddress = addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = READ;
      READ: begin
        busy = 1'b1;
        if (last_addr) state_next = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // 9-bit sums so a wrapped coordinate can never land back on screen
  assign sum_x = {1'b0, ox} + {3'b000, pcol};
  assign sum_y = {2'b00, oy} + {3'b000, prow};

  assign plot   = pv && (spriteColour != TRANSPARENT) &&
                  (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
  assign x      = plot ? sum_x[7:0]   : x_q;
  assign y      = plot ? sum_y[6:0]   : y_q;
  assign colour = plot ? spriteColour : colour_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ox       <= '0;
      oy       <= '0;
      row      <= '0;
      col      <= '0;
      addr     <= '0;
      pv       <= 1'b0;
      prow     <= '0;
      pcol     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      pv   <= (state == READ);
      prow <= row;
      pcol <= col;
      if (state == IDLE && start) begin
        ox   <= originX;
        oy   <= originY;
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (state == READ && !last_addr) begin
        addr <= addr + 11'd1;
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
      if (plot) begin
        x_q      <= sum_x[7:0];
        y_q      <= sum_y[6:0];
        colour_q <= spriteColour;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter
// Stimulus pushes expected plots/done cycles; a negedge monitor pops and compares.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  originX = '0;
  logic [6:0]  originY = '0;
  logic [10:0] spriteAddress;
  logic [2:0]  spriteColour = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .originX(originX), .originY(originY),
    .spriteAddress(spriteAddress), .spriteColour(spriteColour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: mode 1 makes every even address transparent
  int mode = 0;
  function automatic logic [2:0] rom_col(input int a);
    if (mode == 1) return (a % 2 == 0) ? 3'b000 : {a[2:1], 1'b1};
    return 3'b111;
  endfunction

  always @(posedge clk) spriteColour <= rom_col(int'(spriteAddress));

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   failures = 0;
  int   plot_cnt = 0;
  exp_t e;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (plot) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL plot_unexpected: got plot at x=%0d y=%0d expected none (cycle %0d)", x, y, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("plot_cycle", cyc, e.cyc);
        chk("plot_x", int'(x), e.x);
        chk("plot_y", int'(y), e.y);
        chk("plot_colour", int'(colour), e.c);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got done expected none (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic goto_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic draw_start(input int ox, input int oy, input int m, output int s);
    int sx, sy, r, c;
    logic [2:0] pc;
    mode = m;
    originX = 8'(ox);
    originY = 7'(oy);
    start = 1'b1;
    s = cyc;
    plot_cnt = 0;
    for (int a = 0; a < 1600; a++) begin
      r  = a / 40;
      c  = a % 40;
      sx = ox + c;
      sy = oy + r;
      pc = rom_col(a);
      if (pc != 3'b000 && sx < 160 && sy < 120)
        exp_q.push_back('{s + 2 + a, sx % 256, sy % 128, int'(pc)});
    end
    done_q.push_back(s + 1602);
    @(posedge clk);
    #1;
    start = 1'b0;
    originX = 8'hff;
    originY = 7'h7f;
    @(negedge clk);
    chk("busy_cycle1", int'(busy), 1);
  endtask

  task automatic finish_draw(input int s, input int nplots);
    goto_cycle(s + 1602);
    chk("done_pulse", int'(done), 1);
    chk("busy_low_done", int'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("plot_count", plot_cnt, nplots);
  endtask

  int s;
  exp_t keep[$];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_addr", int'(spriteAddress), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // opaque at origin
    draw_start(0, 0, 0, s);
    finish_draw(s, 1600);

    // checkerboard transparency
    draw_start(10, 20, 1, s);
    finish_draw(s, 800);

    // clipped at bottom-right
    draw_start(150, 100, 0, s);
    finish_draw(s, 200);

    // stray starts during and at the end of a draw
    draw_start(5, 7, 0, s);
    goto_cycle(s + 500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    goto_cycle(s + 1602);
    chk("done_before_restart", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ignored_busy", int'(busy), 0);
    chk("restart_ignored_queue", exp_q.size(), 0);
    draw_start(5, 7, 0, s);
    finish_draw(s, 1600);

    // reset mid-draw
    draw_start(0, 0, 0, s);
    goto_cycle(s + 700);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    keep = {};
    foreach (exp_q[i]) if (exp_q[i].cyc <= s + 700) keep.push_back(exp_q[i]);
    exp_q = keep;
    done_q.delete();
    @(negedge clk);
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(spriteAddress), 0);
    chk("abort_done", int'(done), 0);
    goto_cycle(s + 705);
    draw_start(0, 0, 0, s);
    finish_draw(s, 1600);

    // reset and start together in IDLE
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_start_busy", int'(busy), 0);
      chk("rst_start_addr", int'(spriteAddress), 0);
    end
    chk("final_done_queue", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
